// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide sequencer: op codes, FSM states, counter sizing.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH);

  // Iteration counter width for an arbitrary operand width (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply (shift-add) or divide (restoring) datapath.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,   // {upper, lower}: product/multiplier or remainder/quotient
  input  logic [WIDTH-1:0]   opnd_i,  // multiplicand or divisor magnitude
  input  logic               div_i,   // 1 = divide step, 0 = multiply step
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply adds the multiplicand under the multiplier LSB and shifts right;
  // divide shifts the next dividend bit into the remainder and trial-subtracts.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    ge     = (rem_sh >= {1'b0, opnd_i});
    diff   = WIDTH'(rem_sh - {1'b0, opnd_i});
    if (div_i) begin
      acc_o = {(ge ? diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             hilo_w,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic               sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, div_zero_q, div_zero_d, busy_q, busy_d;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign prod      = sq_q ? -acc_q : acc_q;
  assign quo       = sq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem       = sr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div),
    .acc_o  (acc_step)
  );

  // Next-state and result logic; abort overrides every non-IDLE transition.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    sq_d       = sq_q;
    sr_d       = sr_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PREP;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end
      end
      ST_PREP: begin
        sq_d   = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        sr_d   = is_signed & a_q[WIDTH-1];
        dz_d   = is_div && (b_q == '0);
        cnt_d  = '0;
        acc_d  = {WIDTH'(0), (is_div ? a_mag : b_mag)};
        opnd_d = is_div ? b_mag : a_mag;
        // A zero divisor skips the iterations and resolves in FIX.
        state_d = (is_div && (b_q == '0)) ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        if (dz_q) begin
          hi_d       = a_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else if (is_div) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      sq_q       <= 1'b0;
      sr_q       <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      sq_q       <= sq_d;
      sr_q       <= sr_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

  // Stall covers the accepting cycle and every working state, but not DONE.
  assign stall    = ((state_q == ST_IDLE) && start) || (state_q == ST_PREP) ||
                    (state_q == ST_CALC) || (state_q == ST_FIX);
  assign busy     = busy_q;
  assign done     = done_q;
  assign hilo_w   = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed testbench for mdu_seq.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        stall;
  logic        busy;
  logic        done;
  logic        hilo_w;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  mdu_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .abort    (abort),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hilo_w   (hilo_w),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one cycle; returns 1ns after the accepting edge (edge 0).
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after edge 0 until done is seen; -1 if it never arrives.
  task automatic wait_done(output int cyc, output int stall_lows);
    cyc = -1;
    stall_lows = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
      if (stall !== 1'b1) stall_lows++;
    end
  endtask

  task automatic test_reset();
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hilo_w !== 1'b0) begin errors++; $display("FAIL reset_hilo_w got %b want 0", hilo_w); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_multu();
    int cyc, sl;
    op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL multu_stall_start got %b want 1", stall); end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, sl);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", cyc); end
    checks++; if (sl !== 0) begin errors++; $display("FAIL multu_stall_run got %0d low cycles want 0", sl); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want %h", hi, 32'hFFFF_FFFE); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want %h", lo, 32'h0000_0001); end
    checks++; if (hilo_w !== 1'b1) begin errors++; $display("FAIL multu_hilo_w got %b want 1", hilo_w); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL multu_stall_done got %b want 0", stall); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_done got %b want 1", busy); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL multu_div_zero got %b want 0", div_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", done); end
    checks++; if (hilo_w !== 1'b0) begin errors++; $display("FAIL multu_hilo_w_pulse got %b want 0", hilo_w); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_idle got %b want 0", busy); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi_hold got %h want %h", hi, 32'hFFFF_FFFE); end
  endtask

  task automatic test_mult();
    int cyc, sl;
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(cyc, sl);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", cyc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h want %h", lo, 32'hFFFF_FFF1); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL mult_div_zero got %b want 0", div_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int cyc, sl;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, sl);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    @(posedge clk); #1;
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, sl);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want %h", lo, 32'h8000_0000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want %h", hi, 32'h0); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int cyc, sl;
    launch(OP_DIVU, 32'd100, 32'd0);
    wait_done(cyc, sl);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL dz_latency got %0d want 2", cyc); end
    checks++; if (hi !== 32'h0000_0064) begin errors++; $display("FAIL dz_hi got %h want %h", hi, 32'h0000_0064); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h want %h", lo, 32'hFFFF_FFFF); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_zero); end
    checks++; if (hilo_w !== 1'b1) begin errors++; $display("FAIL dz_hilo_w got %b want 1", hilo_w); end
    @(posedge clk); #1;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_pulse got %b want 0", div_zero); end
  endtask

  task automatic test_abort();
    int cyc, sl, done_seen, busy_seen;
    launch(OP_DIVU, 32'd7, 32'd2);
    wait_done(cyc, sl);
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want %h", hi, 32'd1); end
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want %h", lo, 32'd3); end
    @(posedge clk); #1;
    launch(OP_DIVU, 32'd9, 32'd4);
    done_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3; end
      if (i == 6) start = 1'b0;
      if (done === 1'b1) done_seen++;
    end
    abort = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall got %b want 0", stall); end
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || hilo_w === 1'b1) done_seen++;
      if (busy === 1'b1) busy_seen++;
      @(posedge clk); #1;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL abort_start_ignored got %0d busy cycles want 0", busy_seen); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL abort_hi_kept got %h want %h", hi, 32'd1); end
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL abort_lo_kept got %h want %h", lo, 32'd3); end
  endtask

  task automatic test_reset_mid();
    int cyc, sl;
    launch(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rmid_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rmid_lo got %h want %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b want 0", stall); end
    launch(OP_MULTU, 32'd6, 32'd7);
    wait_done(cyc, sl);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL rmid_latency got %0d want 34", cyc); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL rmid_lo42 got %h want %h", lo, 32'd42); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rmid_hi0 got %h want %h", hi, 32'd0); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    op     = 2'b00;
    a      = 32'h0;
    b      = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
